fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Fetch-side controller that sequences the program counter against a handshaked instruction memory.
//  Holds the PC, issues one fetch at a time, and buffers the returned instruction until decode accepts it.
//  Applies branch/jump redirects from execute, and supports halt and misaligned-target trapping.
//  Sits between the PC register/incrementer path and instruction memory; replaces the free-running PC update.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  INSTR_BYTES   4              sequential PC step in bytes
// PORTS
//  clk              in   1   clock, rising edge
//  reset            in   1   asynchronous, active-high reset
//  imem_req         out  1   fetch request to instruction memory
//  imem_addr        out  32  fetch address; stable while imem_req && !imem_ack
//  imem_ack         in   1   request accepted; imem_rdata valid this cycle
//  imem_rdata       in   32  instruction word
//  inst_valid       out  1   buffered instruction available to decode
//  inst_data        out  32  buffered instruction
//  inst_pc          out  32  address of inst_data
//  inst_ready       in   1   decode consumes inst_data this cycle (if inst_valid)
//  redirect_valid   in   1   one-cycle pulse: branch taken or jump
//  redirect_target  in   32  new PC when redirect_valid
//  halt             in   1   level: stop issuing fetches
//  halted           out  1   sequencer is idle in HALT state
//  misalign_err     out  1   sticky: redirect target had [1:0] != 0
// BEHAVIOUR
//  Reset (async): state=BOOT, pc=RESET_VECTOR; all outputs 0 except imem_addr=RESET_VECTOR.
//  FSM states: BOOT, FETCH, HOLD, DRAIN, HALT, TRAP.
//  BOOT: exactly one cycle after reset deasserts; then FETCH, or HALT if halt=1.
//  FETCH: imem_req=1, imem_addr=pc.
//    - On ack: capture rdata/pc into buffer; go to HOLD (inst_valid=1 next cycle).
//    - Minimum fetch-to-valid latency is 1 cycle; ack in the same cycle as req is legal.
//  HOLD: inst_valid=1 and imem_req=0.
//    - On inst_ready: pc<=pc+INSTR_BYTES (mod 2^32, wraps silently); go to FETCH, or HALT if halt=1.
//    - inst_data and inst_pc stay constant while in HOLD.
//  Redirect (redirect_valid=1), all branches take effect next cycle:
//    - target[1:0]!=0 in any state: misalign_err<=1; state->TRAP; pc unchanged.
//    - HOLD: pc<=target; buffer dropped (inst_valid=0); ->FETCH, or HALT if halt=1.
//      Redirect with inst_ready in the same cycle: redirect wins and no +4 is applied.
//    - FETCH with ack the same cycle: pc<=target; rdata discarded; ->FETCH.
//    - FETCH without ack: pc<=target; ->DRAIN.
//      The address must not change mid-request, so imem_addr stays at the old pc in DRAIN.
//    - DRAIN: imem_req=1 at the old address; on ack the data is discarded; ->FETCH at the new pc.
//      A second redirect in DRAIN updates pc and keeps the state DRAIN.
//    - HALT: pc<=target; stay in HALT.
//  HALT: imem_req=0, inst_valid=0, halted=1; on halt=0 go to FETCH.
//    - halt never aborts an outstanding FETCH/DRAIN request; it is honoured at the next FETCH entry.
//  TRAP: all requests off, inst_valid=0; exit only via reset; misalign_err stays 1.
//  Never more than one outstanding imem request; imem_req is registered (state-decoded, no comb path from inputs).
// STRUCTURE
//  Package fetch_pkg: state enum fetch_state_t, RESET_VECTOR default, INSTR_BYTES.
//  Sub-module fetch_pc_reg: 32-bit PC register with async reset to RESET_VECTOR.
//    - Load-enable selects between pc+INSTR_BYTES and redirect_target.
//  Remaining FSM, instruction buffer and sticky flag are inline.
// TESTING
//  T1 Reset/boot: reset 3 cycles, release -> 1 BOOT cycle, then imem_req=1 with imem_addr=0x0.
//  T2 Sequential: imem_ack same cycle, inst_ready held 1.
//    - inst_pc sequence 0x0,0x4,0x8,0xC with matching rdata.
//    - 0xFFFFFFFC wraps to 0x0.
//  T3 Backpressure: inst_ready=0 for 5 cycles -> inst_valid stays 1, inst_data/inst_pc stable, imem_req=0.
//  T4 Redirect in HOLD: target=0x100 with inst_ready=1 -> buffer dropped, next imem_addr=0x100, no +4.
//  T5 Redirect in flight: req at 0x8, redirect 0x200, ack 3 cycles later.
//    - imem_addr stays 0x8 until ack; that data never appears on inst_data.
//    - Next request is at 0x200.
//  T6 Halt/trap: halt=1 during HOLD -> halted=1 after inst_ready; redirect 0x202 -> misalign_err=1, TRAP until reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer.
//   fetch_state_t     : sequencer FSM state encoding
//   RESET_VECTOR_DEF  : default PC loaded on reset
//   INSTR_BYTES_DEF   : default sequential PC step in bytes
//   is_aligned()      : true when an address is word aligned
package fetch_pkg;

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StHold,
    StDrain,
    StHalt,
    StTrap
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES_DEF  = 4;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch sequencer.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-high reset, loads RESET_VECTOR
//   inc_en_i    : advance pc by INSTR_BYTES
//   load_en_i   : load target_i (has priority over inc_en_i)
//   target_i    : redirect target
//   pc_o        : current pc
//   pc_next_o   : value pc takes at the next edge
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned INSTR_BYTES  = INSTR_BYTES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_en_i,
  input  logic        load_en_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_next_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Increment wraps silently modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (load_en_i) begin
      pc_d = target_i;
    end else if (inc_en_i) begin
      pc_d = pc_q + 32'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-side controller: sequences the PC against a handshaked instruction
// memory, keeps at most one request outstanding, buffers one returned
// instruction until decode takes it, and applies redirects, halt and
// misaligned-target trapping.
// Ports:
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   imem_req_o/addr_o   : registered fetch request and address
//   imem_ack_i/rdata_i  : request accepted, instruction word valid this cycle
//   inst_valid_o        : buffered instruction available to decode
//   inst_data_o/pc_o    : buffered instruction and its address
//   inst_ready_i        : decode consumes the buffered instruction
//   redirect_valid_i    : one-cycle branch/jump pulse
//   redirect_target_i   : new pc on redirect
//   halt_i              : level request to stop issuing fetches
//   halted_o            : sequencer idle in halt
//   misalign_err_o      : sticky, a redirect target was not word aligned
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned INSTR_BYTES  = INSTR_BYTES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_data_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic        halt_i,
  output logic        halted_o,
  output logic        misalign_err_o
);

  fetch_state_t state_q, state_d;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        pc_inc;
  logic        capture;
  logic        redir_ok;
  logic        redir_bad;

  logic        imem_req_q;
  logic [31:0] imem_addr_q;
  logic        inst_valid_q;
  logic [31:0] inst_data_q;
  logic [31:0] inst_pc_q;
  logic        halted_q;
  logic        misalign_q;

  fetch_pc_reg #(
    .RESET_VECTOR (RESET_VECTOR),
    .INSTR_BYTES  (INSTR_BYTES)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .inc_en_i  (pc_inc),
    .load_en_i (pc_load),
    .target_i  (redirect_target_i),
    .pc_o      (pc),
    .pc_next_o (pc_next)
  );

  assign redir_ok  = redirect_valid_i && is_aligned(redirect_target_i);
  assign redir_bad = redirect_valid_i && !is_aligned(redirect_target_i);

  // Next-state and pc control. A misaligned redirect overrides everything
  // and leaves the pc untouched.
  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    capture = 1'b0;
    if (redir_bad) begin
      state_d = StTrap;
    end else begin
      case (state_q)
        StBoot: begin
          pc_load = redir_ok;
          state_d = halt_i ? StHalt : StFetch;
        end
        StFetch: begin
          if (redir_ok) begin
            // With ack the returned word is stale and dropped; without ack
            // the request must be completed at the old address first.
            pc_load = 1'b1;
            state_d = imem_ack_i ? StFetch : StDrain;
          end else if (imem_ack_i) begin
            capture = 1'b1;
            state_d = StHold;
          end
        end
        StHold: begin
          // Redirect wins over a same-cycle consume: no increment applied.
          if (redir_ok) begin
            pc_load = 1'b1;
            state_d = halt_i ? StHalt : StFetch;
          end else if (inst_ready_i) begin
            pc_inc  = 1'b1;
            state_d = halt_i ? StHalt : StFetch;
          end
        end
        StDrain: begin
          pc_load = redir_ok;
          if (imem_ack_i) begin
            state_d = halt_i ? StHalt : StFetch;
          end
        end
        StHalt: begin
          pc_load = redir_ok;
          if (!halt_i) begin
            state_d = StFetch;
          end
        end
        StTrap: begin
          state_d = StTrap;
        end
        default: begin
          state_d = StBoot;
        end
      endcase
    end
  end

  // State and all outputs are registered, decoded from the next state so no
  // input reaches imem_req_o combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StBoot;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_VECTOR;
      inst_valid_q <= 1'b0;
      inst_data_q  <= 32'h0;
      inst_pc_q    <= 32'h0;
      halted_q     <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      imem_req_q   <= (state_d == StFetch) || (state_d == StDrain);
      inst_valid_q <= (state_d == StHold);
      halted_q     <= (state_d == StHalt);
      // Address only moves when a fresh fetch starts; DRAIN keeps the old one.
      if (state_d == StFetch) begin
        imem_addr_q <= pc_next;
      end
      if (capture) begin
        inst_data_q <= imem_rdata_i;
        inst_pc_q   <= pc;
      end
      if (redir_bad) begin
        misalign_q <= 1'b1;
      end
    end
  end

  assign imem_req_o     = imem_req_q;
  assign imem_addr_o    = imem_addr_q;
  assign inst_valid_o   = inst_valid_q;
  assign inst_data_o    = inst_data_q;
  assign inst_pc_o      = inst_pc_q;
  assign halted_o       = halted_q;
  assign misalign_err_o = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset/boot, sequential fetch, wrap,
// backpressure, redirects in HOLD and in flight, halt and misalign trap.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        halted;
  logic        misalign_err;

  int n_cmp = 0;
  int n_err = 0;

  fetch_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .imem_req_o        (imem_req),
    .imem_addr_o       (imem_addr),
    .imem_ack_i        (imem_ack),
    .imem_rdata_i      (imem_rdata),
    .inst_valid_o      (inst_valid),
    .inst_data_o       (inst_data),
    .inst_pc_o         (inst_pc),
    .inst_ready_i      (inst_ready),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .halt_i            (halt),
    .halted_o          (halted),
    .misalign_err_o    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset           = 1'b1;
    imem_ack        = 1'b0;
    imem_rdata      = 32'h0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    halt            = 1'b0;

    // T1 reset and boot
    repeat (3) tick();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
    reset = 1'b0;
    #1;
    chk("boot_req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("fetch0_req", {31'h0, imem_req}, 32'h1);
    chk("fetch0_addr", imem_addr, 32'h0);

    // T2 sequential, ack same cycle as req, inst_ready held
    imem_ack   = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", imem_addr, 32'(4 * i));
      imem_rdata = 32'hA000_0000 | 32'(4 * i);
      tick();
      chk("seq_valid", {31'h0, inst_valid}, 32'h1);
      chk("seq_req_off", {31'h0, imem_req}, 32'h0);
      chk("seq_pc", inst_pc, 32'(4 * i));
      chk("seq_data", inst_data, 32'hA000_0000 | 32'(4 * i));
      tick();
    end
    chk("seq_next_addr", imem_addr, 32'h10);
    imem_ack   = 1'b0;
    inst_ready = 1'b0;

    // T3 backpressure
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'h0, inst_valid}, 32'h1);
      chk("bp_data", inst_data, 32'h1234_5678);
      chk("bp_pc", inst_pc, 32'h10);
      chk("bp_req", {31'h0, imem_req}, 32'h0);
    end

    // T4 redirect in HOLD together with inst_ready: redirect wins
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    inst_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    chk("rdh_valid", {31'h0, inst_valid}, 32'h0);
    chk("rdh_req", {31'h0, imem_req}, 32'h1);
    chk("rdh_addr", imem_addr, 32'h100);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0100;
    tick();
    imem_ack = 1'b0;
    chk("rdh_pc", inst_pc, 32'h100);

    // T2b wrap from 0xFFFFFFFC to 0x0
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_0001;
    tick();
    imem_ack = 1'b0;
    chk("wrap_pc_hi", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("wrap_addr_lo", imem_addr, 32'h0);
    chk("wrap_req", {31'h0, imem_req}, 32'h1);

    // T5 redirect while a request at 0x8 is outstanding
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0000;
    tick();
    imem_ack        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h8;
    tick();
    chk("inf_addr8", imem_addr, 32'h8);
    redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_req", {31'h0, imem_req}, 32'h1);
      chk("drain_addr", imem_addr, 32'h8);
      tick();
    end
    chk("drain_addr_last", imem_addr, 32'h8);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("post_drain_addr", imem_addr, 32'h200);
    chk("post_drain_valid", {31'h0, inst_valid}, 32'h0);
    imem_rdata = 32'h0000_0200;
    tick();
    imem_ack = 1'b0;
    chk("post_drain_pc", inst_pc, 32'h200);
    chk("post_drain_data", inst_data, 32'h0000_0200);

    // T6 halt during HOLD, then misaligned redirect traps
    halt       = 1'b1;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("halt_halted", {31'h0, halted}, 32'h1);
    chk("halt_req", {31'h0, imem_req}, 32'h0);
    chk("halt_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    chk("halt_stay", {31'h0, halted}, 32'h1);
    redirect_valid  = 1'b1;
    redirect_target = 32'h202;
    tick();
    redirect_valid = 1'b0;
    halt           = 1'b0;
    chk("trap_misalign", {31'h0, misalign_err}, 32'h1);
    chk("trap_halted", {31'h0, halted}, 32'h0);
    chk("trap_req", {31'h0, imem_req}, 32'h0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    imem_ack        = 1'b1;
    tick();
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
    repeat (3) tick();
    chk("trap_sticky", {31'h0, misalign_err}, 32'h1);
    chk("trap_req_off", {31'h0, imem_req}, 32'h0);
    chk("trap_valid_off", {31'h0, inst_valid}, 32'h0);

    // Reset is the only exit from TRAP
    reset = 1'b1;
    tick();
    chk("rst2_misalign", {31'h0, misalign_err}, 32'h0);
    chk("rst2_addr", imem_addr, 32'h0);
    reset = 1'b0;
    tick();
    chk("rst2_req", {31'h0, imem_req}, 32'h1);
    chk("rst2_fetch_addr", imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
